// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: shifts bitstream words into a serial config chain, or reads it back non-destructively
module cfg_chain_loader #(
    parameter int CHAIN_LEN = 20,
    parameter int WORD_W    = 8,
    parameter int CLK_DIV   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              readback,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              prog_in,
    output logic              prog_clk,
    output logic              prog_en,
    input  logic              prog_out,
    output logic              busy,
    output logic              done
);
    localparam int BW = $clog2(CHAIN_LEN + 1);
    localparam int WW = WORD_W > 1 ? $clog2(WORD_W) : 1;
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, LOW, HIGH, FLUSH, DONE} state_t;

    state_t            state, state_n;
    logic              rb;
    logic              smp;
    logic [BW-1:0]     bcnt;
    logic [WW-1:0]     widx;
    logic [DW-1:0]     dcnt;
    logic [WORD_W-1:0] sr;
    logic              phase_end, last_bit, word_end;

    assign phase_end = dcnt == DW'(CLK_DIV - 1);
    assign last_bit  = bcnt == BW'(CHAIN_LEN - 1);
    assign word_end  = widx == WW'(WORD_W - 1);

    // Everything except prog_clk is a plain decode of the state register.
    // prog_in is taken at the tail sample (readback) so the chain recirculates.
    assign wr_ready = state == FETCH;
    assign rd_valid = state == FLUSH;
    assign busy     = state != IDLE && state != DONE;
    assign prog_en  = busy;
    assign done     = state == DONE;
    assign prog_in  = (state == LOW || state == HIGH) && (rb ? smp : sr[0]);

    // Next-state: FLUSH doubles as the readback word-handshake wait
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? (readback ? LOW : FETCH) : IDLE;
            FETCH:   state_n = wr_valid ? LOW : FETCH;
            LOW:     state_n = phase_end ? HIGH : LOW;
            HIGH:    if (phase_end) state_n = last_bit ? (rb ? FLUSH : DONE) : word_end ? (rb ? FLUSH : FETCH) : LOW;
            FLUSH:   state_n = rd_ready ? (bcnt == BW'(CHAIN_LEN) ? DONE : LOW) : FLUSH;
            default: state_n = IDLE;
        endcase
    end

    // State, registered prog_clk, counters, data shift and readback packing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            prog_clk <= 1'b0;
            rb       <= 1'b0;
            smp      <= 1'b0;
            bcnt     <= '0;
            widx     <= '0;
            dcnt     <= '0;
            sr       <= '0;
            rd_data  <= '0;
        end else begin
            state    <= state_n;
            prog_clk <= state_n == HIGH;
            dcnt     <= state_n != state ? '0 : dcnt + DW'(1);
            if (state == IDLE && start) begin
                rb   <= readback;
                bcnt <= '0;
                widx <= '0;
            end
            if (state == FETCH && wr_valid)
                sr <= wr_data;
            if (state_n == LOW && state != LOW)
                smp <= prog_out;
            if (state == HIGH && phase_end) begin
                bcnt <= bcnt + BW'(1);
                widx <= word_end ? '0 : widx + WW'(1);
                sr   <= sr >> 1;
                if (rb)
                    rd_data <= (widx == '0 ? '0 : rd_data) | (WORD_W'(smp) << widx);
            end
        end
    end
endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb_cfg_chain_loader: randomized scoreboard bench with behavioural chain models
module tb_cfg_chain_loader;
    localparam int L = 20, W = 8, D = 2, NW = (L + W - 1) / W;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         start = 1'b0, readback = 1'b0, wr_valid = 1'b0, rd_ready = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         wr_ready, rd_valid, prog_in, prog_clk, prog_en, prog_out, busy, done;
    logic [W-1:0] rd_data;

    cfg_chain_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .readback(readback),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .prog_in(prog_in), .prog_clk(prog_clk), .prog_en(prog_en), .prog_out(prog_out),
        .busy(busy), .done(done)
    );

    logic       b_start = 1'b0, b_readback = 1'b0, b_wr_valid = 1'b0, b_rd_ready = 1'b0;
    logic [7:0] b_wr_data = '0;
    logic       b_wr_ready, b_rd_valid, b_prog_in, b_prog_clk, b_prog_en, b_prog_out, b_busy, b_done;
    logic [7:0] b_rd_data;

    cfg_chain_loader #(.CHAIN_LEN(8), .WORD_W(8), .CLK_DIV(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .readback(b_readback),
        .wr_data(b_wr_data), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_ready(b_rd_ready),
        .prog_in(b_prog_in), .prog_clk(b_prog_clk), .prog_en(b_prog_en), .prog_out(b_prog_out),
        .busy(b_busy), .done(b_done)
    );

    int checks = 0, failures = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Behavioural chains: bits enter at the head on each prog_clk rise, tail drives prog_out
    logic [L-1:0] chain = '0;
    logic [7:0]   b_chain = '0;
    assign prog_out   = chain[L-1];
    assign b_prog_out = b_chain[7];

    int  mode = 0, b_mode = 0;
    int  edges = 0, b_edges = 0, b_cyc = 0, b_last = -1;
    logic pclk_q = 1'b0, b_pclk_q = 1'b0;
    logic         exp_bits[$];
    logic [W-1:0] exp_rd[$];
    logic         b_bits[$];
    logic [7:0]   b_rd[$];
    logic         ref_bits[L];

    // Monitor for the default instance: chain update, written-bit and readback-word scoreboards
    always @(negedge clk) begin
        if (prog_clk && !pclk_q) begin
            edges <= edges + 1;
            if (prog_en) chain <= {chain[L-2:0], prog_in};
            if (mode == 1) check("write_bit", prog_in, exp_bits.size() ? exp_bits.pop_front() : 2);
        end
        pclk_q <= prog_clk;
        if (rd_valid && rd_ready) check("rd_word", rd_data, exp_rd.size() ? exp_rd.pop_front() : 32'hFFFF_FFFF);
        if (done) check("done_busy", busy, 0);
    end

    // Monitor for the small instance, including the per-bit period
    always @(negedge clk) begin
        b_cyc <= b_cyc + 1;
        if (b_prog_clk && !b_pclk_q) begin
            b_edges <= b_edges + 1;
            if (b_prog_en) b_chain <= {b_chain[6:0], b_prog_in};
            if (b_last >= 0) check("b_period", b_cyc - b_last, 2);
            b_last <= b_cyc;
            if (b_mode == 1) check("b_bit", b_prog_in, b_bits.size() ? b_bits.pop_front() : 2);
        end else if (!b_busy) b_last <= -1;
        b_pclk_q <= b_prog_clk;
        if (b_rd_valid && b_rd_ready) check("b_rd_word", b_rd_data, b_rd.size() ? b_rd.pop_front() : 32'hFFFF_FFFF);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [L-1:0] ref_chain();
        logic [L-1:0] c;
        for (int i = 0; i < L; i++) c[L-1-i] = ref_bits[i];
        return c;
    endfunction

    task automatic do_write(input logic [W-1:0] w [NW], input int stall, output int cyc);
        int k, st, e0;
        logic acc;
        for (int i = 0; i < L; i++) begin
            ref_bits[i] = w[i / W][i % W];
            exp_bits.push_back(w[i / W][i % W]);
        end
        mode = 1; e0 = edges; k = 0; st = 0; cyc = 0;
        wr_data = w[0]; wr_valid = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c < 3000; c++) begin
            @(negedge clk);
            cyc = c + 1;
            if (done) break;
            acc = wr_ready && wr_valid;
            if (wr_ready && !wr_valid) begin
                check("stall_pclk", prog_clk, 0);
                check("stall_en", prog_en, 1);
                st++;
            end
            tick();
            if (acc) begin
                k++;
                wr_data  = k < NW ? w[k] : '0;
                wr_valid = k < NW && !(k == 1 && stall > 0);
            end else if (!wr_valid && k < NW && st >= stall) wr_valid = 1'b1;
        end
        check("write_done", done, 1);
        tick();
        check("write_done_once", done, 0);
        check("write_edges", edges - e0, L);
        check("write_bits_left", exp_bits.size(), 0);
        check("write_chain", chain, ref_chain());
        wr_valid = 1'b0; mode = 0;
    endtask

    task automatic do_read(input int hold);
        logic [W-1:0] wv;
        logic [L-1:0] snap;
        int e0, h;
        for (int i = 0; i < NW; i++) begin
            wv = '0;
            for (int j = 0; j < W && i * W + j < L; j++) wv[j] = ref_bits[i * W + j];
            exp_rd.push_back(wv);
        end
        snap = chain; e0 = edges; h = 0; mode = 2;
        rd_ready = hold == 0;
        readback = 1'b1; start = 1'b1; tick(); start = 1'b0; readback = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done) break;
            if (rd_valid && !rd_ready) begin
                check("hold_pclk", prog_clk, 0);
                h++;
            end
            tick();
            if (h >= hold) rd_ready = 1'b1;
        end
        check("read_done", done, 1);
        tick();
        check("read_done_once", done, 0);
        check("read_edges", edges - e0, L);
        check("read_words_left", exp_rd.size(), 0);
        check("read_chain_kept", chain, snap);
        rd_ready = 1'b0; mode = 0;
    endtask

    task automatic b_wait_done();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (b_done) break;
        end
        check("b_done", b_done, 1);
        tick();
        check("b_done_once", b_done, 0);
    endtask

    initial begin
        logic [W-1:0] words [NW];
        logic [L-1:0] snap0;
        logic [7:0]   b_w, b_exp;
        int cyc, be0, st;

        repeat (3) @(negedge clk);
        check("rst_pclk", prog_clk, 0);
        check("rst_en", prog_en, 0);
        check("rst_in", prog_in, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // asynchronous reset while prog_clk is high
        wr_data = 8'hFF; wr_valid = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (prog_clk) break;
        end
        check("midshift_reached", prog_clk, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pclk", prog_clk, 0);
        check("async_rst_en", prog_en, 0);
        check("async_rst_busy", busy, 0);
        wr_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_pclk", prog_clk, 0);
            check("post_rst_busy", busy, 0);
            check("post_rst_wr_ready", wr_ready, 0);
        end
        tick();

        words = '{8'hA5, 8'h3C, 8'h0F};
        do_write(words, 0, cyc);
        check("write_cycles", cyc, 1 + NW + L * 2 * D + 1);
        check("chain_default", chain, 20'hF3CA5 == 0 ? 0 : ref_chain());
        snap0 = chain;
        do_read(0);
        do_read(0);

        do_write(words, 10, cyc);
        check("stall_cycles", cyc, 1 + NW + L * 2 * D + 1 + 10);
        check("stall_chain", chain, snap0);
        do_read(15);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NW; i++) words[i] = W'($urandom);
            st = $urandom_range(0, 1) ? $urandom_range(1, 6) : 0;
            do_write(words, st, cyc);
            check("rand_cycles", cyc, 1 + NW + L * 2 * D + 1 + st);
            do_read($urandom_range(0, 8));
        end

        // small instance: one word, two-cycle bit period, start ignored while busy
        b_w = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            b_bits.push_back(b_w[i]);
            b_exp[7-i] = b_w[i];
        end
        b_mode = 1; be0 = b_edges;
        b_wr_data = b_w; b_wr_valid = 1'b1;
        b_start = 1'b1; tick(); b_start = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (b_wr_ready) break;
        end
        check("b_fetch", b_wr_ready, 1);
        tick();
        b_wr_valid = 1'b0;
        repeat (3) tick();
        b_start = 1'b1; b_readback = 1'b1; tick(); b_start = 1'b0; b_readback = 1'b0;
        b_wait_done();
        check("b_write_edges", b_edges - be0, 8);
        check("b_bits_left", b_bits.size(), 0);
        check("b_chain", b_chain, b_exp);
        repeat (12) tick();
        check("b_no_extra_edges", b_edges - be0, 8);
        check("b_idle_busy", b_busy, 0);
        b_mode = 2; be0 = b_edges;
        b_rd.push_back(b_w);
        b_rd_ready = 1'b1;
        b_start = 1'b1; b_readback = 1'b1; tick(); b_start = 1'b0; b_readback = 1'b0;
        b_wait_done();
        check("b_read_edges", b_edges - be0, 8);
        check("b_words_left", b_rd.size(), 0);
        check("b_chain_kept", b_chain, b_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
